// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : riscv_mem_pkg
//  Description : Shared types for the load/store memory master. Contains the
//                access-size encoding, the LSU state encoding and the number
//                of bytes per RAM word.
//  Revision    : 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } mem_size_e;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_CAPT  = 3'd2,
        WR_ISSUE = 3'd3,
        RSP      = 3'd4
    } lsu_state_e;

    localparam int WORD_BYTES = 4;

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_lane_align
//  Description : Combinational lane steering for sub-word accesses on a
//                little-endian word RAM.
//                  o_ext    : lane at i_offset extracted from i_word and
//                             sign/zero-extended to DW.
//                  o_merged : i_word with the addressed lane(s) replaced by
//                             the right-aligned bytes of i_wdata.
//  Ports       : i_word   - word read from RAM
//                i_wdata  - right-aligned store data
//                i_offset - byte offset inside the word
//                i_size   - 0=byte, 1=half, 2=word
//                i_signed - sign-extend loads when set
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_lane_align
    import riscv_mem_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [DW-1:0] i_word,
    input  logic [DW-1:0] i_wdata,
    input  logic [1:0]    i_offset,
    input  logic [1:0]    i_size,
    input  logic          i_signed,
    output logic [DW-1:0] o_ext,
    output logic [DW-1:0] o_merged
);

    logic [4:0]    w_bshamt;
    logic [4:0]    w_hshamt;
    logic [DW-1:0] w_bshift;
    logic [DW-1:0] w_hshift;
    logic [DW-1:0] w_mask;
    logic [DW-1:0] w_data;

    always_comb begin
        // Byte lane is offset[1:0]; half lane is offset[1] only.
        w_bshamt = {i_offset, 3'b000};
        w_hshamt = {i_offset[1], 4'b0000};
        w_bshift = i_word >> w_bshamt;
        w_hshift = i_word >> w_hshamt;
        o_ext    = i_word;
        w_mask   = '1;
        w_data   = i_wdata;
        case (i_size)
            SZ_B: begin
                o_ext  = {{(DW-8){i_signed & w_bshift[7]}}, w_bshift[7:0]};
                w_mask = DW'(32'h0000_00FF) << w_bshamt;
                w_data = DW'(i_wdata[7:0]) << w_bshamt;
            end
            SZ_H: begin
                o_ext  = {{(DW-16){i_signed & w_hshift[15]}}, w_hshift[15:0]};
                w_mask = DW'(32'h0000_FFFF) << w_hshamt;
                w_data = DW'(i_wdata[15:0]) << w_hshamt;
            end
            default: ;
        endcase
        o_merged = (i_word & ~w_mask) | (w_data & w_mask);
    end

endmodule
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
//  Module      : lsu_mem_master
//  Description : Load/store initiator driving one port of a word RAM without
//                byte enables. Byte/half stores are done as read-modify-write.
//                One request is outstanding at a time.
//  Ports       : clk/rst                 - clock, async active-high reset
//                req_*                   - request channel (valid/ready)
//                rsp_*                   - response channel (valid/ready)
//                mem_en/wen/addr/din/dout - RAM port (read data one cycle
//                                          after en & !wen)
//  Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master
    import riscv_mem_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic          req_we,
    input  logic [1:0]    req_size,
    input  logic          req_signed,
    input  logic [AW-1:0] req_addr,
    input  logic [DW-1:0] req_wdata,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_rdata,
    output logic          rsp_err,
    output logic          mem_en,
    output logic          mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic [DW-1:0] mem_dout
);

    localparam int c_OFF_W = $clog2(WORD_BYTES);

    generate
        if (DW != 32) begin : g_dw_unsupported
            $error("lsu_mem_master: only DW=32 is supported");
        end
    endgenerate

    lsu_state_e    r_state;
    lsu_state_e    w_state_nxt;

    logic          r_we;
    logic [1:0]    r_size;
    logic          r_signed;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata;
    logic [DW-1:0] r_din;
    logic [DW-1:0] r_rdata;
    logic          r_err;

    logic          w_req_err;
    logic [DW-1:0] w_ext;
    logic [DW-1:0] w_merged;

    // Illegal size or an access not aligned to its own size.
    assign w_req_err = (req_size == 2'd3)
                     | ((req_size == SZ_H) & req_addr[0])
                     | ((req_size == SZ_W) & (|req_addr[1:0]));

    lsu_lane_align #(
        .DW (DW)
    ) u_lane_align (
        .i_word   (mem_dout),
        .i_wdata  (r_wdata),
        .i_offset (r_addr[1:0]),
        .i_size   (r_size),
        .i_signed (r_signed),
        .o_ext    (w_ext),
        .o_merged (w_merged)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (req_valid) begin
                    if (w_req_err) begin
                        w_state_nxt = RSP;
                    end else if (!req_we || (req_size != SZ_W)) begin
                        w_state_nxt = RD_ISSUE;
                    end else begin
                        w_state_nxt = WR_ISSUE;
                    end
                end
            end
            RD_ISSUE: w_state_nxt = RD_CAPT;
            RD_CAPT:  w_state_nxt = r_we ? WR_ISSUE : RSP;
            WR_ISSUE: w_state_nxt = RSP;
            RSP: begin
                if (rsp_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default:  w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we     <= 1'b0;
            r_size   <= 2'd0;
            r_signed <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_din    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_size   <= req_size;
                        r_signed <= req_signed;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_rdata  <= '0;
                        r_err    <= w_req_err;
                        // Word stores skip the read, so their write data is
                        // loaded into the RAM data register right away.
                        if (req_we && (req_size == SZ_W) && !w_req_err) begin
                            r_din <= req_wdata;
                        end
                    end
                end
                RD_CAPT: begin
                    if (r_we) begin
                        r_din <= w_merged;
                    end else begin
                        r_rdata <= w_ext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RSP);
    assign rsp_rdata = r_rdata;
    assign rsp_err   = r_err;
    assign mem_en    = (r_state == RD_ISSUE) || (r_state == WR_ISSUE);
    assign mem_wen   = (r_state == WR_ISSUE);
    assign mem_addr  = {{c_OFF_W{1'b0}}, r_addr[AW-1:c_OFF_W]};
    assign mem_din   = r_din;

endmodule
`default_nettype wire
